// File: rtl/mode3_exp_ctrl_pkg.sv
// Shared constants and types for the softmax mode-3 exponent sequencer.
package mode3_exp_ctrl_pkg;

    localparam int DATAWIDTH  = 16;
    localparam int NUM        = 4;
    localparam int BUF_AWIDTH = 4;
    localparam int NUM_WORDS  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [BUF_AWIDTH-1:0] addr;
    } pipe_entry_t;

endpackage

// File: rtl/mode3_exp_pipe_tracker.sv
// Valid/write-address shift register that follows each issued read through
// the RAM read cycle and the exp lane stages to its output-buffer write.
module mode3_exp_pipe_tracker
    import mode3_exp_ctrl_pkg::*;
#(
    parameter int ADDR_W = BUF_AWIDTH,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              stage_run,
    output logic              stage_run2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_wr
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    always_comb begin
        valid_d   = {valid_q[DEPTH-2:0], push};
        addr_d[0] = push_addr;
        for (int i = 1; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i-1];
        end
        if (clear) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // Slot 0 is the cycle RAM data reaches the lanes; the last slot is the write.
    assign stage_run  = valid_q[0];
    assign stage_run2 = valid_q[1];
    assign wr_en      = valid_q[DEPTH-1];
    assign wr_addr    = addr_q[DEPTH-1];
    assign last_wr    = valid_q[DEPTH-1] & ~(|valid_q[DEPTH-2:0]);

endmodule

// File: rtl/mode3_exp_ctrl.sv
// Mode-3 exponent stage sequencer: streams score-buffer locations into the exp
// lanes and writes results back. Optional cycle counter: MODE3_EXP_PERF_EN.
module mode3_exp_ctrl
    import mode3_exp_ctrl_pkg::*;
#(
    parameter int NUM_GROUPS  = NUM_WORDS / NUM,
    parameter int ADDR_W      = BUF_AWIDTH,
    parameter int EXP_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              stage_run,
    output logic              stage_run2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output state_e            dbg_state
`ifdef MODE3_EXP_PERF_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_GROUPS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic              pipe_clear;
    logic              last_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_base_d  = rd_base_q;
        wr_base_d  = wr_base_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        push       = 1'b0;
        push_addr  = '0;
        pipe_clear = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                // abort outranks a coincident start
                if (start && !abort) begin
                    state_d   = ISSUE;
                    cnt_d     = '0;
                    rd_base_d = rd_base;
                    wr_base_d = wr_base;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = rd_base_q + cnt_q;
                push      = 1'b1;
                push_addr = wr_base_q + cnt_q;
                if (abort) begin
                    state_d    = IDLE;
                    pipe_clear = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d    = IDLE;
                    pipe_clear = 1'b1;
                end else if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mode3_exp_pipe_tracker #(
        .ADDR_W (ADDR_W),
        .DEPTH  (1 + EXP_LATENCY)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .clear      (pipe_clear),
        .push       (push),
        .push_addr  (push_addr),
        .stage_run  (stage_run),
        .stage_run2 (stage_run2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .last_wr    (last_wr)
    );

    assign dbg_state = state_q;

`ifdef MODE3_EXP_PERF_EN
    logic [15:0] cycle_cnt_q;

    // Counts every cycle from the one after accept through the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if (state_q == IDLE && state_d == ISSUE) begin
            cycle_cnt_q <= '0;
        end else if (state_q != IDLE && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mode3_exp_ctrl.sv
// Self-checking bench for mode3_exp_ctrl: per-cycle control windows plus a
// read/write address scoreboard.
module tb_mode3_exp_ctrl;
    import mode3_exp_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int G  = 8;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [AW-1:0] rd_base = '0;
    logic [AW-1:0] wr_base = '0;
    logic          busy, done, rd_en, stage_run, stage_run2, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    state_e        dbg_state;
`ifdef MODE3_EXP_PERF_EN
    logic [15:0]   cycle_cnt;
`endif

    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wr_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mode3_exp_ctrl #(
        .NUM_GROUPS  (G),
        .ADDR_W      (AW),
        .EXP_LATENCY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rd_base    (rd_base),
        .wr_base    (wr_base),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .stage_run  (stage_run),
        .stage_run2 (stage_run2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .dbg_state  (dbg_state)
`ifdef MODE3_EXP_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        n_checks++;
        if ({rd_en, stage_run, stage_run2, wr_en, busy, done} !== 6'b0 || rd_addr !== '0 || wr_addr !== '0)
            $display("FAIL reset_outputs got ctl=%b rd_addr=%0d wr_addr=%0d exp all zero",
                     {rd_en, stage_run, stage_run2, wr_en, busy, done}, rd_addr, wr_addr);
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        else n_pass++;
`ifdef MODE3_EXP_PERF_EN
        n_checks++;
        if (cycle_cnt !== 16'd0) $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt);
        else n_pass++;
`endif
        start = 1'b0;
        reset = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored busy got=%b exp=0", busy);
        else n_pass++;
    endtask

    // Full run; cycle 0 is the accept cycle. Optionally pulses a stray start in ISSUE cycle 3.
    task automatic test_full_run(input string name, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                                 input bit inject);
        logic [5:0] got_v, exp_v;
        logic [AW-1:0] e;
        int dones = 0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int k = 0; k < G; k++) begin
            exp_rd_q.push_back(AW'(rb + k));
            exp_wr_q.push_back(AW'(wb + k));
        end
        start   = 1'b1;
        rd_base = rb;
        wr_base = wb;
        for (int c = 1; c <= G + 6; c++) begin
            step();
            start = inject && (c == 3);
            if (start) begin
                rd_base = 4'd9;
                wr_base = 4'd9;
            end
            got_v = {rd_en, stage_run, stage_run2, wr_en, busy, done};
            exp_v = {c <= G, c >= 2 && c <= G + 1, c >= 3 && c <= G + 2,
                     c >= 4 && c <= G + 3, c <= G + 3, c == G + 4};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL %s ctl c=%0d got=%b exp=%b", name, c, got_v, exp_v);
            else n_pass++;
            if (done === 1'b1) dones++;
            if (rd_en === 1'b1) begin
                n_checks++;
                if (exp_rd_q.size() == 0) $display("FAIL %s rd_addr c=%0d got=%0d exp=none", name, c, rd_addr);
                else begin
                    e = exp_rd_q.pop_front();
                    if (rd_addr !== e) $display("FAIL %s rd_addr c=%0d got=%0d exp=%0d", name, c, rd_addr, e);
                    else n_pass++;
                end
            end
            if (wr_en === 1'b1) begin
                n_checks++;
                if (exp_wr_q.size() == 0) $display("FAIL %s wr_addr c=%0d got=%0d exp=none", name, c, wr_addr);
                else begin
                    e = exp_wr_q.pop_front();
                    if (wr_addr !== e) $display("FAIL %s wr_addr c=%0d got=%0d exp=%0d", name, c, wr_addr, e);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || dones != 1)
            $display("FAIL %s leftover rd=%0d wr=%0d dones=%0d exp 0 0 1", name,
                     exp_rd_q.size(), exp_wr_q.size(), dones);
        else n_pass++;
`ifdef MODE3_EXP_PERF_EN
        n_checks++;
        if (cycle_cnt !== 16'(G + 4)) $display("FAIL %s cycle_cnt got=%0d exp=%0d", name, cycle_cnt, G + 4);
        else n_pass++;
`endif
    endtask

    task automatic test_abort();
        logic [5:0] got_v, exp_v;
        logic [AW-1:0] e;
        bit seen_done = 0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int k = 0; k < 4; k++) exp_rd_q.push_back(AW'(4'd2 + k));
        exp_wr_q.push_back(4'd6);
        start   = 1'b1;
        rd_base = 4'd2;
        wr_base = 4'd6;
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            abort = (c == 4);
            got_v = {rd_en, stage_run, stage_run2, wr_en, busy, done};
            exp_v = {c <= 4, c >= 2 && c <= 4, c >= 3 && c <= 4, c == 4, c <= 4, 1'b0};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL abort ctl c=%0d got=%b exp=%b", c, got_v, exp_v);
            else n_pass++;
            if (rd_en === 1'b1) begin
                n_checks++;
                if (exp_rd_q.size() == 0) $display("FAIL abort rd_addr c=%0d got=%0d exp=none", c, rd_addr);
                else begin
                    e = exp_rd_q.pop_front();
                    if (rd_addr !== e) $display("FAIL abort rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, e);
                    else n_pass++;
                end
            end
            if (wr_en === 1'b1) begin
                n_checks++;
                if (exp_wr_q.size() == 0) $display("FAIL abort wr_addr c=%0d got=%0d exp=none", c, wr_addr);
                else begin
                    e = exp_wr_q.pop_front();
                    if (wr_addr !== e) $display("FAIL abort wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, e);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0)
            $display("FAIL abort leftover rd=%0d wr=%0d exp 0 0", exp_rd_q.size(), exp_wr_q.size());
        else n_pass++;
        // restart one cycle after the abort edge
        start   = 1'b1;
        rd_base = 4'd0;
        wr_base = 4'd0;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 4'd0)
            $display("FAIL abort_restart got busy=%b rd_en=%b rd_addr=%0d exp 1 1 0", busy, rd_en, rd_addr);
        else n_pass++;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            step();
            if (done === 1'b1) seen_done = 1;
        end
        n_checks++;
        if (!seen_done) $display("FAIL abort_restart_done got=timeout exp=done");
        else n_pass++;
        step();
    endtask

    task automatic test_reset_drain();
        logic [5:0] got_v, exp_v;
        logic [AW-1:0] e;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int k = 0; k < G; k++) exp_rd_q.push_back(AW'(4'd3 + k));
        for (int k = 0; k < G - 2; k++) exp_wr_q.push_back(AW'(4'd10 + k));
        start   = 1'b1;
        rd_base = 4'd3;
        wr_base = 4'd10;
        for (int c = 1; c <= G + 6; c++) begin
            step();
            start = 1'b0;
            reset = (c == G + 1);
            got_v = {rd_en, stage_run, stage_run2, wr_en, busy, done};
            exp_v = {c <= G, c >= 2 && c <= G + 1, c >= 3 && c <= G + 1,
                     c >= 4 && c <= G + 1, c <= G + 1, 1'b0};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL reset_drain ctl c=%0d got=%b exp=%b", c, got_v, exp_v);
            else n_pass++;
            if (c > G + 1) begin
                n_checks++;
                if (rd_addr !== '0 || wr_addr !== '0 || dbg_state !== IDLE)
                    $display("FAIL reset_drain idle c=%0d got rd_addr=%0d wr_addr=%0d state=%0d exp 0 0 0",
                             c, rd_addr, wr_addr, dbg_state);
                else n_pass++;
            end
            if (rd_en === 1'b1) begin
                n_checks++;
                if (exp_rd_q.size() == 0) $display("FAIL reset_drain rd_addr c=%0d got=%0d exp=none", c, rd_addr);
                else begin
                    e = exp_rd_q.pop_front();
                    if (rd_addr !== e) $display("FAIL reset_drain rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, e);
                    else n_pass++;
                end
            end
            if (wr_en === 1'b1) begin
                n_checks++;
                if (exp_wr_q.size() == 0) $display("FAIL reset_drain wr_addr c=%0d got=%0d exp=none", c, wr_addr);
                else begin
                    e = exp_wr_q.pop_front();
                    if (wr_addr !== e) $display("FAIL reset_drain wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, e);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0)
            $display("FAIL reset_drain leftover rd=%0d wr=%0d exp 0 0", exp_rd_q.size(), exp_wr_q.size());
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_run("nominal", 4'd0, 4'd0, 1'b0);
        test_full_run("wrap", 4'd14, 4'd13, 1'b0);
        test_full_run("ignored_start", 4'd5, 4'd1, 1'b1);
        test_abort();
        test_reset_drain();
        test_full_run("back_to_back", 4'd7, 4'd11, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
